// File: rtl/shift_arbiter32.sv
// Two-port round-robin front end for a single 32-bit right barrel shifter.
// A one-entry output register gives a fixed one-cycle latency at full throughput.

module shift_right32 (
    input  logic [31:0] inp,
    input  logic [4:0]  shamt,
    input  logic        mode,
    output logic [31:0] res
);

    logic        fill;
    logic [31:0] s1, s2, s4, s8;

    // Logarithmic stages; fill is zero for SRL and the operand sign for SRA
    always_comb begin
        fill = mode & inp[31];
        s1   = shamt[0] ? {{1{fill}},  inp[31:1]} : inp;
        s2   = shamt[1] ? {{2{fill}},  s1[31:2]}  : s1;
        s4   = shamt[2] ? {{4{fill}},  s2[31:4]}  : s2;
        s8   = shamt[3] ? {{8{fill}},  s4[31:8]}  : s4;
        res  = shamt[4] ? {{16{fill}}, s8[31:16]} : s8;
    end

endmodule

module shift_arbiter32 #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_inp,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_inp,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic             req1_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_src
);

    logic             prio;
    logic             grant0, grant1;
    logic             can_accept;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] mux_inp;
    logic [SHW-1:0]   mux_shamt;
    logic             mux_mode;
    logic [WIDTH-1:0] shift_res;

    // A lone requester always wins; prio only breaks ties
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !prio);
        grant1     = req1_valid && (!req0_valid || prio);
        can_accept = !res_valid || res_ready;
        req0_ready = grant0 && can_accept;
        req1_ready = grant1 && can_accept;
        accept     = req0_ready || req1_ready;
        sel        = grant1;
        mux_inp    = sel ? req1_inp   : req0_inp;
        mux_shamt  = sel ? req1_shamt : req0_shamt;
        mux_mode   = sel ? req1_mode  : req0_mode;
    end

    shift_right32 u_shift (
        .inp   (mux_inp),
        .shamt (mux_shamt),
        .mode  (mux_mode),
        .res   (shift_res)
    );

    // A new accept overwrites the output register even while it drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_src   <= 1'b0;
            prio      <= 1'b0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_data  <= shift_res;
            res_src   <= sel;
            prio      <= ~sel;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter32.sv
// Directed and randomized checks of shift_arbiter32 against an arithmetic reference model.

module tb_shift_arbiter32;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_inp, req1_inp;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        req0_mode, req1_mode;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_src;

    int checks;
    int errors;

    logic        m_valid;
    logic [31:0] m_data;
    logic        m_src;
    logic        m_prio;

    shift_arbiter32 #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_inp   (req0_inp),
        .req0_shamt (req0_shamt),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_inp   (req1_inp),
        .req1_shamt (req1_shamt),
        .req1_mode  (req1_mode),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_src    (res_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Right shift as floor division by a power of two on the operand's value
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s, input logic m);
        longint v, d, q;
        v = m ? longint'($signed(x)) : longint'({32'd0, x});
        d = longint'(1) << s;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        return q[31:0];
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_valid"}, {31'd0, res_valid}, {31'd0, m_valid});
        checkValue({tag, "_data"},  res_data, m_data);
        checkValue({tag, "_src"},   {31'd0, res_src}, {31'd0, m_src});
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_data  = 32'd0;
        m_src   = 1'b0;
        m_prio  = 1'b0;
    endtask

    // Drive one cycle of inputs, check readies mid-cycle, then the registered result after the edge
    task automatic applyStimulus(input string tag,
                                 input logic v0, input logic [31:0] i0, input logic [4:0] s0, input logic md0,
                                 input logic v1, input logic [31:0] i1, input logic [4:0] s1, input logic md1,
                                 input logic rr);
        logic g0, g1, can, e0, e1;
        req0_valid = v0; req0_inp = i0; req0_shamt = s0; req0_mode = md0;
        req1_valid = v1; req1_inp = i1; req1_shamt = s1; req1_mode = md1;
        res_ready  = rr;
        g0  = v0 && (!v1 || m_prio == 1'b0);
        g1  = v1 && (!v0 || m_prio == 1'b1);
        can = !m_valid || rr;
        e0  = g0 && can;
        e1  = g1 && can;
        #3;
        checkValue({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, e0});
        checkValue({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, e1});
        @(posedge clk);
        if (e0 || e1) begin
            m_valid = 1'b1;
            m_src   = e1;
            m_data  = e1 ? ref_shift(i1, s1, md1) : ref_shift(i0, s0, md0);
            m_prio  = ~e1;
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] r;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        req0_valid = 0; req0_inp = 0; req0_shamt = 0; req0_mode = 0;
        req1_valid = 0; req1_inp = 0; req1_shamt = 0; req1_mode = 0;
        res_ready = 1'b1;
        modelReset();
        #12;
        checkOutput("reset");
        checkValue("reset_ready0", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus("basic", 1, 32'd150, 5'd2, 0, 0, 0, 0, 0, 1);
        checkValue("basic_lit", res_data, 32'd37);
        applyStimulus("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus("sra", 0, 0, 0, 0, 1, -32'sd13, 5'd3, 1, 1);
        checkValue("sra_lit", res_data, 32'hFFFF_FFFE);
        checkValue("sra_src", {31'd0, res_src}, 32'd1);
        applyStimulus("srl", 0, 0, 0, 0, 1, -32'sd13, 5'd3, 0, 1);
        checkValue("srl_lit", res_data, 32'h1FFF_FFFE);

        for (int k = 0; k < 4; k++) begin
            applyStimulus("rr", 1, 32'd92, 5'd4, 0, 1, -32'sd127, 5'd5, 1, 1);
            checkValue("rr_src_lit", {31'd0, res_src}, k % 2);
            checkValue("rr_data_lit", res_data, (k % 2 == 0) ? 32'd5 : -32'sd4);
        end
        applyStimulus("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus("bp_fill", 1, 32'h1234_5678, 5'd8, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("bp_stall", 1, 32'hDEAD_BEEF, 5'd4, 1, 1, 32'hCAFE_0000, 5'd16, 0, 0);
            checkValue("bp_hold_lit", res_data, 32'h0012_3456);
        end
        applyStimulus("bp_drain", 1, 32'hDEAD_BEEF, 5'd4, 1, 1, 32'hCAFE_0000, 5'd16, 0, 1);
        checkValue("bp_nobubble", {31'd0, res_valid}, 32'd1);
        checkValue("bp_drain_lit", res_data, 32'h0000_CAFE);

        applyStimulus("b_sra31", 1, 32'h8000_0000, 5'd31, 1, 0, 0, 0, 0, 1);
        checkValue("b_sra31_lit", res_data, 32'hFFFF_FFFF);
        applyStimulus("b_srl31", 1, 32'h8000_0000, 5'd31, 0, 0, 0, 0, 0, 1);
        checkValue("b_srl31_lit", res_data, 32'h0000_0001);
        r = $urandom;
        applyStimulus("b_pass", 0, 0, 0, 0, 1, r, 5'd0, 1, 1);
        checkValue("b_pass_lit", res_data, r);
        applyStimulus("b_127a", 1, 32'd127, 5'd1, 0, 0, 0, 0, 0, 1);
        checkValue("b_127a_lit", res_data, 32'd63);
        applyStimulus("b_127l", 1, 32'd127, 5'd1, 1, 0, 0, 0, 0, 1);
        checkValue("b_127l_lit", res_data, 32'd63);

        applyStimulus("rst_fill", 0, 0, 0, 0, 1, 32'hF000_0000, 5'd4, 1, 0);
        applyStimulus("rst_stall", 1, 32'd5, 5'd1, 0, 1, 32'd9, 5'd1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus("rst_first", 1, 32'd64, 5'd3, 0, 1, 32'd64, 5'd2, 0, 1);
        checkValue("rst_first_src", {31'd0, res_src}, 32'd0);

        for (int k = 0; k < 300; k++) begin
            applyStimulus("rand",
                          1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
